// File: rtl/load_unit_pipelined.sv
// Pipelined load execution unit: computes base+offset, reads data memory with MEM_LAT latency,
// merges bytes from a window of recent stores and returns extended results in order on the CDB.
module load_unit_pipelined #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 6,
  parameter int SB_DEPTH = 4,
  parameter int MEM_LAT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_width,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_offset,
  output logic             mem_rd_en,
  output logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  input  logic [3:0]       st_be,
  input  logic             flush,
  output logic             cdb_valid,
  input  logic             cdb_ready,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_data,
  output logic             cdb_exc,
  output logic [XLEN-1:0]  lb_addr
);

  localparam int RQ = MEM_LAT + 1;
  localparam int PW = $clog2(RQ);
  localparam int SW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  ea;
    logic [2:0]       width;
    logic             exc;
    logic [3:0]       fmask;
    logic [XLEN-1:0]  fdata;
  } pipe_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic             exc;
    logic [XLEN-1:0]  ea;
  } res_t;

  function automatic logic same_word(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return ((a ^ b) & WORD_MASK) == '0;
  endfunction

  // Store window
  logic [SB_DEPTH-1:0] sb_v_q;
  logic [XLEN-1:0]     sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0]     sb_data_q [SB_DEPTH];
  logic [3:0]          sb_be_q   [SB_DEPTH];
  logic [SW-1:0]       sb_wp_q;

  // Load pipe and result FIFO
  logic [MEM_LAT-1:0] pv_q;
  pipe_t              pipe_q [MEM_LAT];
  res_t               fifo_q [RQ];
  logic [PW-1:0]      rd_q, wr_q;
  logic [PW:0]        cnt_q;

  logic [XLEN-1:0] ea;
  logic            in_exc, accept, push, pop;
  logic [3:0]      inflight, occ;
  logic [3:0]      fmask;
  logic [XLEN-1:0] fdata;
  pipe_t           in_ent, tail;
  res_t            res_d, head;

  assign ea = in_base + in_offset;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    in_exc = 1'b1;
    case (in_width)
      3'b000, 3'b100: in_exc = 1'b0;
      3'b001, 3'b101: in_exc = ea[0];
      3'b010:         in_exc = (ea[1:0] != 2'b00);
      default:        in_exc = 1'b1;
    endcase
  end

  // Credit check counts the result leaving this cycle so accepts can stream at full rate.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + {3'b000, pv_q[i]};
    occ      = inflight + 4'(cnt_q) - {3'b000, pop};
    in_ready = reset && !flush && (occ < 4'(RQ));
  end

  assign accept    = in_valid && in_ready;
  assign mem_rd_en = accept && !in_exc;
  assign mem_addr  = ea & WORD_MASK;

  // Oldest-to-youngest walk so younger stores overwrite older bytes; a store this cycle is youngest.
  always_comb begin
    logic [SW-1:0] idx;
    fmask = '0;
    fdata = '0;
    idx   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = SW'((int'(sb_wp_q) + i) % SB_DEPTH);
      if (sb_v_q[idx] && same_word(sb_addr_q[idx], ea)) begin
        for (int b = 0; b < 4; b++) begin
          if (sb_be_q[idx][b]) begin
            fmask[b]        = 1'b1;
            fdata[8*b +: 8] = sb_data_q[idx][8*b +: 8];
          end
        end
      end
    end
    if (st_valid && same_word(st_addr, ea)) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          fmask[b]        = 1'b1;
          fdata[8*b +: 8] = st_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    in_ent       = '0;
    in_ent.tag   = in_tag;
    in_ent.ea    = ea;
    in_ent.width = in_width;
    in_ent.exc   = in_exc;
    in_ent.fmask = fmask;
    in_ent.fdata = fdata;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sb_v_q  <= '0;
      sb_wp_q <= '0;
    end else if (st_valid) begin
      sb_v_q[sb_wp_q] <= 1'b1;
      sb_wp_q         <= (sb_wp_q == SW'(SB_DEPTH - 1)) ? '0 : sb_wp_q + 1'b1;
    end
  end

  // NOTE: payload arrays carry no reset; their valid bits and counters alone decide visibility.
  always_ff @(posedge clk) begin
    if (st_valid) begin
      sb_addr_q[sb_wp_q] <= st_addr;
      sb_data_q[sb_wp_q] <= st_data;
      sb_be_q[sb_wp_q]   <= st_be;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= accept;
      for (int k = 1; k < MEM_LAT; k++) pv_q[k] <= pv_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= in_ent;
    for (int k = 1; k < MEM_LAT; k++) pipe_q[k] <= pipe_q[k-1];
  end

  assign tail = pipe_q[MEM_LAT-1];
  assign push = pv_q[MEM_LAT-1] && !flush;

  // Memory data arrives while the entry sits in the last pipe stage.
  always_comb begin
    logic [XLEN-1:0] raw;
    logic [7:0]      lane8;
    logic [15:0]     lane16;
    raw = '0;
    for (int b = 0; b < 4; b++)
      raw[8*b +: 8] = tail.fmask[b] ? tail.fdata[8*b +: 8] : mem_rdata[8*b +: 8];
    case (tail.ea[1:0])
      2'b00:   lane8 = raw[7:0];
      2'b01:   lane8 = raw[15:8];
      2'b10:   lane8 = raw[23:16];
      default: lane8 = raw[31:24];
    endcase
    lane16    = tail.ea[1] ? raw[31:16] : raw[15:0];
    res_d     = '0;
    res_d.tag = tail.tag;
    res_d.ea  = tail.ea;
    res_d.exc = tail.exc;
    if (!tail.exc) begin
      case (tail.width[1:0])
        2'b00:   res_d.data = {{(XLEN-8){lane8[7] & ~tail.width[2]}}, lane8};
        2'b01:   res_d.data = {{(XLEN-16){lane16[15] & ~tail.width[2]}}, lane16};
        default: res_d.data = raw;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PW'(RQ - 1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_q <= (rd_q == PW'(RQ - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= res_d;
  end

  assign head      = fifo_q[rd_q];
  assign cdb_valid = (cnt_q != '0);
  assign pop       = cdb_valid && cdb_ready;
  assign cdb_tag   = cdb_valid ? head.tag  : '0;
  assign cdb_data  = cdb_valid ? head.data : '0;
  assign cdb_exc   = cdb_valid && head.exc;
  assign lb_addr   = cdb_valid ? head.ea   : '0;

endmodule
